// File: rtl/matraptor_pkg.sv
// ============================================================================
// matraptor_pkg : widths, FSM state encoding and partial-product beat shared
//                 by the stream generator and the merge PE.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package matraptor_pkg;

  localparam int unsigned C_DATA_W = 32;
  localparam int unsigned C_IDX_W  = 16;
  localparam int unsigned C_PTR_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_A_PTR0 = 4'd1,
    S_A_PTR1 = 4'd2,
    S_A_ENT  = 4'd3,
    S_B_PTR0 = 4'd4,
    S_B_PTR1 = 4'd5,
    S_B_ENT  = 4'd6,
    S_EMIT   = 4'd7,
    S_FIN    = 4'd8
  } pp_state_t;

  typedef struct packed {
    logic [C_DATA_W-1:0] val;
    logic [C_IDX_W-1:0]  row;
    logic [C_IDX_W-1:0]  col;
    logic                last;
  } pp_beat_t;

endpackage

`default_nettype wire

// File: rtl/pp_stream_gen.sv
// ============================================================================
// pp_stream_gen : walks CSR matrices A and B and streams the partial products
//                 a(i,k)*b(k,j) in row / A-entry / B-entry order.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pp_stream_gen
  import matraptor_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned IDX_W  = C_IDX_W,
  parameter int unsigned PTR_W  = C_PTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  a_ptr_addr,
  input  logic [PTR_W-1:0]  a_ptr_data,
  output logic [PTR_W-1:0]  a_ent_addr,
  input  logic [IDX_W-1:0]  a_col_data,
  input  logic [DATA_W-1:0] a_val_data,
  output logic [IDX_W-1:0]  b_ptr_addr,
  input  logic [PTR_W-1:0]  b_ptr_data,
  output logic [PTR_W-1:0]  b_ent_addr,
  input  logic [IDX_W-1:0]  b_col_data,
  input  logic [DATA_W-1:0] b_val_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] C_IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] C_PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  pp_state_t         r_state;
  logic [IDX_W-1:0]  r_num_rows;
  logic [IDX_W-1:0]  r_row;
  logic [PTR_W-1:0]  r_a_idx;
  logic [PTR_W-1:0]  r_a_end;
  logic [PTR_W-1:0]  r_b_end;
  logic [DATA_W-1:0] r_a_val;
  logic [IDX_W-1:0]  r_a_ptr_addr;
  logic [PTR_W-1:0]  r_a_ent_addr;
  logic [IDX_W-1:0]  r_b_ptr_addr;
  logic [PTR_W-1:0]  r_b_ent_addr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_val;
  logic [IDX_W-1:0]  r_out_row;
  logic [IDX_W-1:0]  r_out_col;
  logic              r_out_last;
  logic              r_done;

  logic [DATA_W-1:0] w_prod;
  logic [PTR_W-1:0]  w_a_next;
  logic [PTR_W-1:0]  w_b_next;
  logic [IDX_W-1:0]  w_row_next;
  logic              w_a_more;
  logic              w_b_more;
  logic              w_row_more;

  assign w_prod     = r_a_val * b_val_data;
  assign w_a_next   = r_a_idx + C_PTR_ONE;
  assign w_b_next   = r_b_ent_addr + C_PTR_ONE;
  assign w_row_next = r_row + C_IDX_ONE;
  assign w_a_more   = (w_a_next != r_a_end);
  assign w_b_more   = (w_b_next != r_b_end);
  assign w_row_more = (w_row_next != r_num_rows);

  // The A row-pointer address always sits one row ahead, so ptr[i] is already
  // on a_ptr_data when A_PTR0 is entered and each pointer pair costs two cycles.
  // The B entry address doubles as the current B entry index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_num_rows   <= '0;
      r_row        <= '0;
      r_a_idx      <= '0;
      r_a_end      <= '0;
      r_b_end      <= '0;
      r_a_val      <= '0;
      r_a_ptr_addr <= '0;
      r_a_ent_addr <= '0;
      r_b_ptr_addr <= '0;
      r_b_ent_addr <= '0;
      r_out_valid  <= 1'b0;
      r_out_val    <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_last   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_rows <= num_rows;
            r_row      <= '0;
            if (num_rows == '0) begin
              r_state <= S_FIN;
            end else begin
              r_a_ptr_addr <= C_IDX_ONE;
              r_state      <= S_A_PTR0;
            end
          end
        end
        S_A_PTR0: begin
          r_a_idx      <= a_ptr_data;
          r_a_ent_addr <= a_ptr_data;
          r_state      <= S_A_PTR1;
        end
        S_A_PTR1: begin
          r_a_end <= a_ptr_data;
          if (a_ptr_data != r_a_idx) begin
            r_state <= S_A_ENT;
          end else if (w_row_more) begin
            r_row        <= w_row_next;
            r_a_ptr_addr <= r_a_ptr_addr + C_IDX_ONE;
            r_state      <= S_A_PTR0;
          end else begin
            r_state <= S_FIN;
          end
        end
        S_A_ENT: begin
          // Prefetch the next A entry so a later return to A_ENT finds it ready.
          r_a_val      <= a_val_data;
          r_b_ptr_addr <= a_col_data;
          r_a_ent_addr <= w_a_next;
          r_state      <= S_B_PTR0;
        end
        S_B_PTR0: begin
          r_b_ptr_addr <= r_b_ptr_addr + C_IDX_ONE;
          r_state      <= S_B_PTR1;
        end
        S_B_PTR1: begin
          r_b_ent_addr <= b_ptr_data;
          r_state      <= S_B_ENT;
        end
        S_B_ENT: begin
          r_b_end <= b_ptr_data;
          if (b_ptr_data != r_b_ent_addr) begin
            r_state <= S_EMIT;
          end else if (w_a_more) begin
            r_a_idx <= w_a_next;
            r_state <= S_A_ENT;
          end else if (w_row_more) begin
            r_row        <= w_row_next;
            r_a_ptr_addr <= r_a_ptr_addr + C_IDX_ONE;
            r_state      <= S_A_PTR0;
          end else begin
            r_state <= S_FIN;
          end
        end
        S_EMIT: begin
          if (!r_out_valid) begin
            r_out_val   <= w_prod;
            r_out_row   <= r_row;
            r_out_col   <= b_col_data;
            r_out_last  <= !w_a_more && !w_b_more;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_b_more) begin
              r_b_ent_addr <= w_b_next;
              r_state      <= S_B_ENT;
            end else if (w_a_more) begin
              r_a_idx <= w_a_next;
              r_state <= S_A_ENT;
            end else if (w_row_more) begin
              r_row        <= w_row_next;
              r_a_ptr_addr <= r_a_ptr_addr + C_IDX_ONE;
              r_state      <= S_A_PTR0;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_done       <= 1'b1;
          r_a_ptr_addr <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign a_ptr_addr = r_a_ptr_addr;
  assign a_ent_addr = r_a_ent_addr;
  assign b_ptr_addr = r_b_ptr_addr;
  assign b_ent_addr = r_b_ent_addr;
  assign out_valid  = r_out_valid;
  assign out_val    = r_out_val;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign out_last   = r_out_last;

endmodule

`default_nettype wire
